// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg
// Shared definitions for the PC redirect sequencer:
//   - pcSrcSel_e : PC-source mux select encodings
//   - state_e    : sequencer states
//   - excCause_e : exception cause encodings reported on exc_cause
//   - default exception vector byte addresses
//   - width of the vector-fetch wait counter
package pc_redirect_pkg;

    typedef enum logic [2:0] {
        SEL_PC4    = 3'b000,  // ALU direct (PC+4)
        SEL_ALUOUT = 3'b001,  // branch target
        SEL_JUMP   = 3'b010,  // jump target
        SEL_VECTOR = 3'b011,  // sign-extended vector byte from memory
        SEL_EPC    = 3'b100   // return from exception
    } pcSrcSel_e;

    typedef enum logic [2:0] {
        IDLE,
        REDIRECT,
        EXC_SAVE,
        EXC_FETCH,
        EXC_LOAD
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OPCODE   = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_DIVZERO  = 2'b11
    } excCause_e;

    localparam logic [7:0] VEC_OPCODE_DEF   = 8'd253;
    localparam logic [7:0] VEC_OVERFLOW_DEF = 8'd254;
    localparam logic [7:0] VEC_DIVZERO_DEF  = 8'd255;

    // Holds MEM_LATENCY values 1..4.
    localparam int unsigned WAIT_CNT_W = 3;

endpackage

// File: rtl/pc_redirect_wait_cnt.sv
// pc_redirect_wait_cnt
// Loadable down-counter timing the exception-vector memory fetch.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low
//   load      in   load loadValue (takes priority over dec)
//   dec       in   decrement by one (saturates at zero)
//   loadValue in   WIDTH  value to load
//   fetchDone out  high while the count equals 1 (last fetch cycle)
module pc_redirect_wait_cnt #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] loadValue,
    output logic             fetchDone
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign fetchDone = (count == WIDTH'(1));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Next-PC sequencer for the multicycle datapath: chooses the PC source,
// pulses pc_write, saves EPC and fetches the exception vector byte.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-low
//   req_valid      in   request strobe, sampled only while ready=1
//   req_inc/req_branch/req_jump/req_rte  in  normal redirect kinds
//   exc_opcode/exc_overflow/exc_divzero  in  exception causes
//   ready          out  high in IDLE only
//   pc_source_sel  out  3  PC mux select (see pcSrcSel_e)
//   pc_write       out  one-cycle PC load pulse
//   epc_write      out  one-cycle EPC capture pulse
//   mem_read       out  vector fetch request
//   vec_addr       out  8  vector byte address, valid while mem_read=1
//   exc_cause      out  2  last exception cause, held until next exception
//   done           out  one-cycle completion pulse
// Build option: define PC_REDIRECT_DIVZERO_EN to honour exc_divzero;
// otherwise it is ignored and cause 11 is never produced.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter logic [7:0]  VEC_OPCODE   = VEC_OPCODE_DEF,
    parameter logic [7:0]  VEC_OVERFLOW = VEC_OVERFLOW_DEF,
    parameter logic [7:0]  VEC_DIVZERO  = VEC_DIVZERO_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_inc,
    input  logic       req_branch,
    input  logic       req_jump,
    input  logic       req_rte,
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_divzero,
    output logic       ready,
    output logic [2:0] pc_source_sel,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_read,
    output logic [7:0] vec_addr,
    output logic [1:0] exc_cause,
    output logic       done
);

    state_e     state, nextState;
    pcSrcSel_e  selReg, selNext;
    logic [7:0] vecReg, vecNext;
    excCause_e  causeReg, causeNext;
    logic       fetchDone;

`ifndef PC_REDIRECT_DIVZERO_EN
    logic unusedDivzero;
    assign unusedDivzero = exc_divzero;
`endif

    pc_redirect_wait_cnt #(
        .WIDTH(WAIT_CNT_W)
    ) waitCnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == EXC_SAVE),
        .dec      (state == EXC_FETCH),
        .loadValue(WAIT_CNT_W'(MEM_LATENCY)),
        .fetchDone(fetchDone)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            selReg   <= SEL_PC4;
            vecReg   <= '0;
            causeReg <= CAUSE_NONE;
        end else begin
            state    <= nextState;
            selReg   <= selNext;
            vecReg   <= vecNext;
            causeReg <= causeNext;
        end
    end

    always_comb begin
        nextState = state;
        selNext   = selReg;
        vecNext   = vecReg;
        causeNext = causeReg;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (exc_opcode) begin
                        nextState = EXC_SAVE;
                        causeNext = CAUSE_OPCODE;
                        vecNext   = VEC_OPCODE;
                    end else if (exc_overflow) begin
                        nextState = EXC_SAVE;
                        causeNext = CAUSE_OVERFLOW;
                        vecNext   = VEC_OVERFLOW;
`ifdef PC_REDIRECT_DIVZERO_EN
                    end else if (exc_divzero) begin
                        nextState = EXC_SAVE;
                        causeNext = CAUSE_DIVZERO;
                        vecNext   = VEC_DIVZERO;
`endif
                    end else if (req_rte) begin
                        nextState = REDIRECT;
                        selNext   = SEL_EPC;
                    end else if (req_jump) begin
                        nextState = REDIRECT;
                        selNext   = SEL_JUMP;
                    end else if (req_branch) begin
                        nextState = REDIRECT;
                        selNext   = SEL_ALUOUT;
                    end else if (req_inc) begin
                        nextState = REDIRECT;
                        selNext   = SEL_PC4;
                    end
                end
            end
            REDIRECT:  nextState = IDLE;
            EXC_SAVE:  nextState = EXC_FETCH;
            EXC_FETCH: if (fetchDone) nextState = EXC_LOAD;
            EXC_LOAD:  nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state and latched fields.
    always_comb begin
        ready         = (state == IDLE);
        pc_write      = (state == REDIRECT) || (state == EXC_LOAD);
        done          = pc_write;
        epc_write     = (state == EXC_SAVE);
        mem_read      = (state == EXC_FETCH);
        vec_addr      = vecReg;
        exc_cause     = causeReg;
        pc_source_sel = SEL_PC4;
        if (state == REDIRECT) begin
            pc_source_sel = selReg;
        end else if (state == EXC_LOAD) begin
            pc_source_sel = SEL_VECTOR;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl
// Self-checking bench for pc_redirect_ctrl (MEM_LATENCY=2). A reference
// model turns each request into the expected per-cycle output trace.
module tb_pc_redirect_ctrl;

    localparam int unsigned LAT = 2;
`ifdef PC_REDIRECT_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_inc, req_branch, req_jump, req_rte;
    logic       exc_opcode, exc_overflow, exc_divzero;
    logic       ready, pc_write, epc_write, mem_read, done;
    logic [2:0] pc_source_sel;
    logic [7:0] vec_addr;
    logic [1:0] exc_cause;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .MEM_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_inc      (req_inc),
        .req_branch   (req_branch),
        .req_jump     (req_jump),
        .req_rte      (req_rte),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_divzero  (exc_divzero),
        .ready        (ready),
        .pc_source_sel(pc_source_sel),
        .pc_write     (pc_write),
        .epc_write    (epc_write),
        .mem_read     (mem_read),
        .vec_addr     (vec_addr),
        .exc_cause    (exc_cause),
        .done         (done)
    );

    typedef struct packed {
        logic       rdy;
        logic [2:0] sel;
        logic       pw;
        logic       epw;
        logic       mr;
        logic [7:0] vec;
        logic [1:0] cause;
        logic       dn;
    } snap_t;

    snap_t      expQ[$];
    logic [1:0] expCause;
    int         nCompared = 0;
    int         nMismatch = 0;

    function automatic snap_t idleSnap();
        snap_t s;
        s       = '0;
        s.rdy   = 1'b1;
        s.cause = expCause;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.rdy   = ready;
        s.sel   = pc_source_sel;
        s.pw    = pc_write;
        s.epw   = epc_write;
        s.mr    = mem_read;
        s.vec   = mem_read ? vec_addr : 8'h00;
        s.cause = exc_cause;
        s.dn    = done;
        return s;
    endfunction

    task automatic driveReq(input logic v, inc, br, jp, rte, eop, eov, edz);
        req_valid = v;  req_inc = inc; req_branch = br; req_jump = jp;
        req_rte = rte;  exc_opcode = eop; exc_overflow = eov; exc_divzero = edz;
    endtask

    task automatic driveJunk();
        logic [7:0] r;
        r = 8'($urandom);
        driveReq(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]);
    endtask

    // Reference model: expected outputs for every cycle after acceptance,
    // ending with the first cycle back in IDLE.
    task automatic buildTrace(input logic v, inc, br, jp, rte, eop, eov, edz);
        snap_t      s;
        logic       isExc, isNorm;
        logic [1:0] c;
        logic [7:0] va;
        logic [2:0] sel;
        isExc = 1'b0; isNorm = 1'b0; c = 2'd0; va = 8'd0; sel = 3'd0;
        expQ.delete();
        if (v) begin
            if (eop)               begin isExc = 1'b1; c = 2'd1; va = 8'd253; end
            else if (eov)          begin isExc = 1'b1; c = 2'd2; va = 8'd254; end
            else if (edz && DZ_EN) begin isExc = 1'b1; c = 2'd3; va = 8'd255; end
            else if (rte)          begin isNorm = 1'b1; sel = 3'd4; end
            else if (jp)           begin isNorm = 1'b1; sel = 3'd2; end
            else if (br)           begin isNorm = 1'b1; sel = 3'd1; end
            else if (inc)          begin isNorm = 1'b1; sel = 3'd0; end
        end
        if (isExc) begin
            expCause = c;
            s = idleSnap(); s.rdy = 1'b0; s.epw = 1'b1;
            expQ.push_back(s);
            for (int unsigned i = 0; i < LAT; i++) begin
                s = idleSnap(); s.rdy = 1'b0; s.mr = 1'b1; s.vec = va;
                expQ.push_back(s);
            end
            s = idleSnap(); s.rdy = 1'b0; s.sel = 3'd3; s.pw = 1'b1; s.dn = 1'b1;
            expQ.push_back(s);
        end else if (isNorm) begin
            s = idleSnap(); s.rdy = 1'b0; s.sel = sel; s.pw = 1'b1; s.dn = 1'b1;
            expQ.push_back(s);
        end
        expQ.push_back(idleSnap());
    endtask

    // Called at #1 after an edge with the DUT idle; returns in the same phase.
    task automatic runRequest(input string name,
                              input logic v, inc, br, jp, rte, eop, eov, edz);
        snap_t got;
        driveReq(v, inc, br, jp, rte, eop, eov, edz);
        buildTrace(v, inc, br, jp, rte, eop, eov, edz);
        @(posedge clk); #1;
        for (int i = 0; i < expQ.size(); i++) begin
            got = observe();
            nCompared++;
            if (got !== expQ[i]) begin
                nMismatch++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, got, expQ[i]);
            end
            if (i < expQ.size() - 1) begin
                driveJunk();
                @(posedge clk); #1;
            end else begin
                driveReq(0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic test_reset();
        snap_t got;
        expCause = 2'd0;
        driveReq(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #2;
        got = observe();
        nCompared++;
        if (got !== idleSnap() || vec_addr !== 8'h00) begin
            nMismatch++;
            $display("FAIL reset: got %h vec %h expected %h vec 00", got, vec_addr, idleSnap());
        end
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        got = observe();
        nCompared++;
        if (got !== idleSnap()) begin
            nMismatch++;
            $display("FAIL reset_release: got %h expected %h", got, idleSnap());
        end
    endtask

    task automatic test_branch();
        runRequest("branch", 1, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jump_inc();
        runRequest("jump_inc", 1, 1, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_overflow_jump();
        runRequest("overflow_jump", 1, 0, 0, 1, 0, 0, 1, 0);
    endtask

    task automatic test_opcode_divzero();
        runRequest("opcode_divzero", 1, 0, 0, 0, 0, 1, 0, 1);
        runRequest("divzero_only", 1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_rte();
        runRequest("overflow_pre_rte", 1, 0, 0, 0, 0, 0, 1, 0);
        runRequest("rte", 1, 1, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic test_empty();
        runRequest("empty_req", 1, 0, 0, 0, 0, 0, 0, 0);
        runRequest("no_valid", 0, 1, 1, 1, 1, 1, 1, 1);
    endtask

    task automatic test_back_to_back();
        runRequest("b2b_inc", 1, 1, 0, 0, 0, 0, 0, 0);
        runRequest("b2b_branch", 1, 0, 1, 0, 0, 0, 0, 0);
        runRequest("b2b_opcode", 1, 0, 0, 0, 0, 1, 0, 0);
        runRequest("b2b_jump", 1, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic v, inc, br, jp, rte, eop, eov, edz;
        for (int n = 0; n < 60; n++) begin
            v   = ($urandom_range(0, 7) != 0);
            inc = ($urandom_range(0, 1) == 0);
            br  = ($urandom_range(0, 2) == 0);
            jp  = ($urandom_range(0, 3) == 0);
            rte = ($urandom_range(0, 4) == 0);
            eop = ($urandom_range(0, 7) == 0);
            eov = ($urandom_range(0, 6) == 0);
            edz = ($urandom_range(0, 5) == 0);
            runRequest("random", v, inc, br, jp, rte, eop, eov, edz);
        end
    endtask

    task automatic test_reset_mid_fetch();
        snap_t got;
        driveReq(1, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        driveReq(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        nCompared++;
        if (mem_read !== 1'b1) begin
            nMismatch++;
            $display("FAIL mid_fetch_setup: mem_read %b expected 1", mem_read);
        end
        #2;
        reset = 1'b0;
        expCause = 2'd0;
        #1;
        got = observe();
        nCompared++;
        if (got !== idleSnap() || vec_addr !== 8'h00) begin
            nMismatch++;
            $display("FAIL reset_async: got %h vec %h expected %h vec 00", got, vec_addr, idleSnap());
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            got = observe();
            nCompared++;
            if (got !== idleSnap()) begin
                nMismatch++;
                $display("FAIL reset_hold %0d: got %h expected %h", k, got, idleSnap());
            end
        end
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        runRequest("inc_after_reset", 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_inc();
        test_overflow_jump();
        test_opcode_divzero();
        test_rte();
        test_empty();
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencer that owns the next-PC selection of the multicycle datapath: it decides which source is loaded into the PC and when PC is written. It also saves the faulting PC into EPC and fetches the exception handler address from the vector bytes in memory. It sits between the main control FSM, which raises one request per instruction, and the PC-source mux, whose select and write enable it drives.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from mem_read assertion to valid mem_byte_sext data (1..4).
- VEC_OPCODE, 8'd253: vector byte address for invalid opcode.
- VEC_OVERFLOW, 8'd254: vector byte address for arithmetic overflow.
- VEC_DIVZERO, 8'd255: vector byte address for divide by zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request strobe from main control; sampled only when ready=1.
- req_inc / req_branch / req_jump / req_rte  in  1 each  normal redirect kinds.
- exc_opcode / exc_overflow / exc_divzero  in  1 each  exception causes.
- ready  out  1  high in IDLE only.
- pc_source_sel  out  3  mux select: 000 PC+4 (ALU direct), 001 ALUOut (branch target), 010 jump target, 011 vector (mem sign-extend), 100 EPC.
- pc_write  out  1  one-cycle PC load pulse.
- epc_write  out  1  one-cycle EPC capture pulse (EPC <= ALU direct = PC+4 minus 4 done by datapath).
- mem_read  out  1  vector fetch request.
- vec_addr  out  8  vector byte address, valid while mem_read=1.
- exc_cause  out  2  00 none, 01 opcode, 10 overflow, 11 divzero; held until next exception or reset.
- done  out  1  one-cycle pulse in the cycle the redirect completes.

## Operation
- States: IDLE, REDIRECT, EXC_SAVE, EXC_FETCH, EXC_LOAD.
- IDLE: ready=1. On req_valid, priority exc_opcode > exc_overflow > exc_divzero > req_rte > req_jump > req_branch > req_inc. An exception goes to EXC_SAVE and latches exc_cause plus vec_addr. A normal request latches the select and goes to REDIRECT. If req_valid=1 with no kind bit set, the request is ignored and the FSM stays in IDLE.
- REDIRECT: pc_write=1, pc_source_sel = latched select, done=1 -> IDLE.
- EXC_SAVE: epc_write=1, pc_source_sel=000 -> EXC_FETCH; wait counter loaded with MEM_LATENCY.
- EXC_FETCH: mem_read=1, vec_addr held; counter decrements each cycle; counter==1 -> EXC_LOAD.
- EXC_LOAD: pc_source_sel=011, pc_write=1, done=1 -> IDLE.
- Request inputs are ignored outside IDLE. exc_cause changes only on entry to EXC_SAVE.

## Timing
- Reset (async, any state): state=IDLE, ready=1, pc_source_sel=000, pc_write=0, epc_write=0, mem_read=0, vec_addr=0, exc_cause=00, done=0. A reset mid-exception abandons it with no pc_write.
- Normal redirect: request accepted at edge N; pc_write and done high during cycle N+1; ready returns at N+2.
- Exception: epc_write in cycle N+1; mem_read for MEM_LATENCY cycles; pc_write and done in cycle N+2+MEM_LATENCY.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- pc_write and epc_write are never high in the same cycle.

## Configuration
- PC_REDIRECT_DIVZERO_EN defined: exc_divzero is honoured with VEC_DIVZERO and cause 11.
- Not defined: exc_divzero is ignored. A request carrying only that bit is treated as carrying no kind bit. Cause 11 is never produced.

## Structure
- Shared package pc_redirect_pkg holds the pc_source_sel encodings, the state enum, the exc_cause encodings, and the default vector addresses.
- One sub-module, pc_redirect_wait_cnt: loadable down-counter that produces the fetch-complete flag.

## Test plan
- req_valid with req_branch=1 -> next cycle pc_source_sel=001, pc_write=1, done=1; ready back 2 cycles after acceptance.
- req_valid with req_jump and req_inc both set -> sel=010; exactly one pc_write.
- exc_overflow and req_jump together, MEM_LATENCY=2 -> epc_write, then 2 cycles of mem_read with vec_addr=254, then sel=011 with pc_write. exc_cause=10.
- exc_opcode with exc_divzero -> vec_addr=253, exc_cause=01; with the macro undefined and only exc_divzero set -> no activity, ready stays 1.
- req_rte -> sel=100, pc_write=1; exc_cause keeps its previous value.
- reset driven low during EXC_FETCH -> all outputs at reset values immediately, no pc_write; a new req_inc after release completes normally.
